v_writeback: RTL

//  Write-back stage: consumes the memory stage's result (ife/Ri/write data), registers it in the
//  MEM/WB pipeline register and commits it to the 32x32 register file one cycle later.

---
 rtl/v_writeback_pkg.sv | 18 +
 rtl/v_regfile.sv | 51 +++++
 rtl/v_writeback.sv | 98 +++++++++
 3 files changed

// File: rtl/v_writeback_pkg.sv
// Shared write-back definitions: default widths, the hard-wired zero register index,
// and opcode field encodings common to the memory/EX/WB stages.
package v_writeback_pkg;

  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int CNTW_DEF = 32;
  localparam int REG_ZERO = 0;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_ALUI   = 7'b0010011,
    OP_STORE  = 7'b0100011,
    OP_ALU    = 7'b0110011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

endpackage

// File: rtl/v_regfile.sv
// 2**AW x DW register file: one synchronous write port, two asynchronous read ports,
// async clear; index 0 is never written and always reads zero.
module v_regfile
  import v_writeback_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic [AW-1:0] ra1_i,
  input  logic [AW-1:0] ra2_i,
  output logic [DW-1:0] rd1_o,
  output logic [DW-1:0] rd2_o
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] mem_q [NREG];
  logic          wr_en;

  assign wr_en = we_i && (wa_i != AW'(REG_ZERO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = '0;
    if (ra1_i != AW'(REG_ZERO)) begin
      rd1_o = mem_q[ra1_i];
    end
  end

  always_comb begin
    rd2_o = '0;
    if (ra2_i != AW'(REG_ZERO)) begin
      rd2_o = mem_q[ra2_i];
    end
  end

endmodule

// File: rtl/v_writeback.sv
// Write-back stage: MEM/WB register, commit into the register file one edge later,
// write-through bypass on both decode read ports, retired-instruction counter. Never stalls.
module v_writeback
  import v_writeback_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_wbi,
  input  logic            ife_wbi,
  input  logic [AW-1:0]   Ri_wbi,
  input  logic [DW-1:0]   write_wbi,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [DW-1:0]   rd1,
  output logic [DW-1:0]   rd2,
  output logic            ife_wbo,
  output logic [AW-1:0]   Ri_wbo,
  output logic [DW-1:0]   write_wbo,
  output logic [CNTW-1:0] retired
);

  typedef struct packed {
    logic          valid;
    logic          ife;
    logic [AW-1:0] ri;
    logic [DW-1:0] data;
  } wb_t;

  wb_t             wb_q, wb_d;
  logic [CNTW-1:0] retired_q, retired_d;
  logic [DW-1:0]   rf_rd1, rf_rd2;

  always_comb begin
    wb_d.valid = valid_wbi;
    wb_d.ife   = valid_wbi & ife_wbi;
    wb_d.ri    = Ri_wbi;
    wb_d.data  = write_wbi;
  end

  // The instruction leaving the WB slot on this edge is the one being counted.
  always_comb begin
    retired_d = retired_q + CNTW'(wb_q.valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q      <= '0;
      retired_q <= '0;
    end else begin
      wb_q      <= wb_d;
      retired_q <= retired_d;
    end
  end

  v_regfile #(
    .DW (DW),
    .AW (AW)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we_i  (wb_q.ife),
    .wa_i  (wb_q.ri),
    .wd_i  (wb_q.data),
    .ra1_i (ra1),
    .ra2_i (ra2),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2)
  );

  // The WB slot holds the youngest write, so it takes priority over the array.
  always_comb begin
    rd1 = rf_rd1;
    if (ra1 == AW'(REG_ZERO)) begin
      rd1 = '0;
    end else if (wb_q.ife && (wb_q.ri == ra1)) begin
      rd1 = wb_q.data;
    end
  end

  always_comb begin
    rd2 = rf_rd2;
    if (ra2 == AW'(REG_ZERO)) begin
      rd2 = '0;
    end else if (wb_q.ife && (wb_q.ri == ra2)) begin
      rd2 = wb_q.data;
    end
  end

  assign ife_wbo   = wb_q.ife;
  assign Ri_wbo    = wb_q.ri;
  assign write_wbo = wb_q.data;
  assign retired   = retired_q;

endmodule
